// File: rtl/wb_reg_slave.sv
// wb_reg_slave: Wishbone classic register slave with ID, interrupt enable,
// write-1-to-clear interrupt status and NUM_REGS general registers.
//   clk, rst            : clock, synchronous active-high reset
//   wbs_*_i             : Wishbone request (cyc, stb, we, sel, adr, dat)
//   wbs_ack_o/wbs_dat_o : registered acknowledge and read data
//   wbs_int_o           : registered OR of (IRQ_STATUS & IRQ_ENABLE)
//   irq_i               : rising-edge interrupt sources
//   reg_o               : flattened general registers, reg k at [32k+31:32k]
module wb_reg_slave #(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] DRT_ID      = 32'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wbs_we_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  wbs_int_o,
  input  logic [NUM_IRQ-1:0]    irq_i,
  output logic [32*NUM_REGS-1:0] reg_o
);

  localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t               state, state_nxt;
  logic [2:0]           cnt, cnt_nxt;
  logic                 ack_nxt;
  logic                 commit;
  logic                 req;
  logic [31:0]          regs [NUM_REGS];
  logic [NUM_IRQ-1:0]   irq_en, irq_stat, irq_prev, irq_rise, irq_clr;
  logic [31:0]          wmask, gidx, rdata, en_wdata;
  logic                 is_gen, wr;

  assign req   = wbs_cyc_i & wbs_stb_i;
  assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign gidx  = wbs_adr_i - 32'd3;
  assign is_gen = (wbs_adr_i >= 32'd3) && (wbs_adr_i <= 32'(NUM_REGS + 2));
  assign wr    = commit & wbs_we_i;

  // Handshake: the access is committed exactly once, on the edge that enters ACK.
  // The counter is checked before decrementing so the total latency is WAIT_STATES+1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = 1'b0;
    commit    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_nxt = S_ACK;
            ack_nxt   = 1'b1;
            commit    = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 3'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == 3'd1) begin
          state_nxt = S_ACK;
          ack_nxt   = 1'b1;
          commit    = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      S_ACK: begin
        if (req) ack_nxt   = 1'b1;
        else     state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (wbs_adr_i == 32'd0)      rdata = DRT_ID;
    else if (wbs_adr_i == 32'd1) rdata = 32'(irq_en);
    else if (wbs_adr_i == 32'd2) rdata = 32'(irq_stat);
    else if (is_gen)             rdata = regs[gidx[IW-1:0]];
  end

  assign en_wdata = (32'(irq_en) & ~wmask) | (wbs_dat_i & wmask);
  assign irq_rise = irq_i & ~irq_prev;
  assign irq_clr  = (wr && wbs_adr_i == 32'd2) ? (wbs_dat_i[NUM_IRQ-1:0] & wmask[NUM_IRQ-1:0]) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      wbs_ack_o <= ack_nxt;
      if (commit && !wbs_we_i) wbs_dat_o <= rdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (rst)
        regs[k] <= '0;
      else if (wr && is_gen && gidx == k)
        regs[k] <= (regs[k] & ~wmask) | (wbs_dat_i & wmask);
    end
  end

  // A new edge wins over a simultaneous write-1-to-clear of the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en    <= '0;
      irq_stat  <= '0;
      irq_prev  <= '0;
      wbs_int_o <= 1'b0;
    end else begin
      irq_prev  <= irq_i;
      irq_stat  <= (irq_stat & ~irq_clr) | irq_rise;
      wbs_int_o <= |(irq_stat & irq_en);
      if (wr && wbs_adr_i == 32'd1) irq_en <= en_wdata[NUM_IRQ-1:0];
    end
  end

  always_comb begin
    reg_o = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) reg_o[32*k +: 32] = regs[k];
  end

endmodule

// File: tb/tb_wb_reg_slave.sv
// Self-checking bench for wb_reg_slave: two instances (zero and three wait
// states) driven by directed and random Wishbone traffic against a simple
// array-based register model.
module tb_wb_reg_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        we  [2];
  logic        cyc [2];
  logic        stb [2];
  logic [3:0]  sel [2];
  logic [31:0] adr [2];
  logic [31:0] dat [2];
  logic [31:0] irq [2];
  logic [1:0]  ack, intr;
  logic [63:0] dato;
  logic [255:0] rego0;
  logic [127:0] rego1;

  int checks = 0;
  int errors = 0;

  wb_reg_slave #(.NUM_REGS(8), .NUM_IRQ(8), .WAIT_STATES(0), .DRT_ID(32'h1234_5678)) u0 (
    .clk(clk), .rst(rst[0]), .wbs_we_i(we[0]), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]),
    .wbs_sel_i(sel[0]), .wbs_adr_i(adr[0]), .wbs_dat_i(dat[0]), .wbs_ack_o(ack[0]),
    .wbs_dat_o(dato[31:0]), .wbs_int_o(intr[0]), .irq_i(irq[0][7:0]), .reg_o(rego0));

  wb_reg_slave #(.NUM_REGS(4), .NUM_IRQ(4), .WAIT_STATES(3), .DRT_ID(32'h5)) u1 (
    .clk(clk), .rst(rst[1]), .wbs_we_i(we[1]), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]),
    .wbs_sel_i(sel[1]), .wbs_adr_i(adr[1]), .wbs_dat_i(dat[1]), .wbs_ack_o(ack[1]),
    .wbs_dat_o(dato[63:32]), .wbs_int_o(intr[1]), .irq_i(irq[1][3:0]), .reg_o(rego1));

  // Reference model state
  logic [31:0] m_regs [2][8];
  logic [31:0] m_en [2], m_st [2], m_prev [2];

  function automatic int nregs(int d);              return (d == 0) ? 8 : 4; endfunction
  function automatic int wstates(int d);            return (d == 0) ? 0 : 3; endfunction
  function automatic logic [31:0] idval(int d);     return (d == 0) ? 32'h1234_5678 : 32'h5; endfunction
  function automatic logic [31:0] imask(int d);     return (d == 0) ? 32'hFF : 32'hF; endfunction
  function automatic logic [31:0] bmask(logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = s[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [31:0] m_read(int d, logic [31:0] a);
    if (a == 0) return idval(d);
    if (a == 1) return m_en[d];
    if (a == 2) return m_st[d];
    if (a >= 3 && a <= 32'(nregs(d) + 2)) return m_regs[d][int'(a) - 3];
    return 32'h0;
  endfunction

  function automatic void m_write(int d, logic [31:0] a, logic [3:0] s, logic [31:0] v);
    logic [31:0] m;
    m = bmask(s);
    if (a == 1) m_en[d] = ((m_en[d] & ~m) | (v & m)) & imask(d);
    else if (a == 2) m_st[d] = m_st[d] & ~(v & m);
    else if (a >= 3 && a <= 32'(nregs(d) + 2))
      m_regs[d][int'(a) - 3] = (m_regs[d][int'(a) - 3] & ~m) | (v & m);
  endfunction

  function automatic void m_reset(int d);
    for (int k = 0; k < 8; k++) m_regs[d][k] = '0;
    m_en[d] = '0; m_st[d] = '0; m_prev[d] = '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dout(int d);
    return (d == 0) ? dato[31:0] : dato[63:32];
  endfunction

  function automatic logic [31:0] reg_slice(int d, int k);
    return (d == 0) ? rego0[32*k +: 32] : rego1[32*k +: 32];
  endfunction

  task automatic check_regs(input int d);
    for (int k = 0; k < nregs(d); k++) check("reg_o", reg_slice(d, k), m_regs[d][k]);
  endtask

  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] v, output logic [31:0] rd);
    int lat;
    bit seen;
    @(negedge clk);
    we[d] = w; adr[d] = a; sel[d] = s; dat[d] = v; cyc[d] = 1'b1; stb[d] = 1'b1;
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (ack[d]) seen = 1;
    end
    check("ack_latency", 32'(lat), 32'(wstates(d) + 1));
    rd = dout(d);
    if (!w) check("read_data", rd, m_read(d, a));
    else m_write(d, a, s, v);
    @(negedge clk);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    @(posedge clk); #1;
    check("ack_release", 32'(ack[d]), 32'h0);
  endtask

  task automatic drive_irq(input int d, input logic [31:0] v);
    logic [31:0] vm;
    vm = v & imask(d);
    @(negedge clk);
    irq[d] = vm;
    m_st[d] = m_st[d] | (vm & ~m_prev[d]);
    m_prev[d] = vm;
    @(posedge clk); @(posedge clk); #1;
    check("int_o", 32'(intr[d]), 32'(|(m_st[d] & m_en[d])));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, a;
    int d;
    bit seen;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; we[i] = 0; cyc[i] = 0; stb[i] = 0; sel[i] = '0;
      adr[i] = '0; dat[i] = '0; irq[i] = '0;
      m_reset(i);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_ack", 32'(ack[i]), 32'h0);
      check("rst_dat", dout(i), 32'h0);
      check("rst_int", 32'(intr[i]), 32'h0);
      check_regs(i);
    end
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Full-word write/read, zero wait states
    xfer(0, 1, 3, 4'hF, 32'hDEADBEEF, rd);
    xfer(0, 0, 3, 4'hF, 32'h0, rd);
    check("req034_read", rd, 32'hDEADBEEF);
    check("req034_reg_o", rego0[31:0], 32'hDEADBEEF);

    // Byte-lane write
    xfer(0, 1, 4, 4'b0101, 32'h11223344, rd);
    xfer(0, 0, 4, 4'hF, 32'h0, rd);
    check("req035_read", rd, 32'h00220044);
    xfer(0, 1, 5, 4'b0000, 32'hFFFFFFFF, rd);
    check_regs(0);

    // Three wait states: ID read, then aborted strobe
    xfer(1, 0, 0, 4'hF, 32'h0, rd);
    check("req036_id", rd, 32'h5);
    @(negedge clk);
    we[1] = 1; adr[1] = 3; sel[1] = 4'hF; dat[1] = 32'hAAAA5555; cyc[1] = 1; stb[1] = 1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    stb[1] = 0; cyc[1] = 0; we[1] = 0;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (ack[1]) seen = 1; end
    check("abort_no_ack", 32'(seen), 32'h0);
    check_regs(1);

    // Interrupt set / clear / simultaneous edge and clear
    xfer(0, 1, 1, 4'hF, 32'h1, rd);
    drive_irq(0, 32'h1);
    check("req037_int_set", 32'(intr[0]), 32'h1);
    xfer(0, 0, 2, 4'hF, 32'h0, rd);
    check("req037_status", rd, 32'h1);
    drive_irq(0, 32'h0);
    xfer(0, 1, 2, 4'hF, 32'h1, rd);
    check("req037_int_clr", 32'(intr[0]), 32'h0);
    @(negedge clk);
    irq[0] = 32'h1;
    we[0] = 1; adr[0] = 2; sel[0] = 4'hF; dat[0] = 32'h1; cyc[0] = 1; stb[0] = 1;
    @(posedge clk); #1;
    check("same_cycle_ack", 32'(ack[0]), 32'h1);
    m_write(0, 2, 4'hF, 32'h1);
    m_st[0] = m_st[0] | 32'h1;
    m_prev[0] = 32'h1;
    @(negedge clk);
    cyc[0] = 0; stb[0] = 0; we[0] = 0;
    @(posedge clk); #1;
    xfer(0, 0, 2, 4'hF, 32'h0, rd);
    check("req037_set_wins", rd, 32'h1);
    check("req037_int_again", 32'(intr[0]), 32'h1);
    xfer(0, 1, 2, 4'hF, 32'hFFFFFFFF, rd);
    xfer(0, 0, 2, 4'hF, 32'h0, rd);
    check("level_no_reset", rd, 32'h0);
    drive_irq(0, 32'h0);

    // Out-of-range and ID writes
    xfer(0, 0, 32'h100, 4'hF, 32'h0, rd);
    check("req038_read", rd, 32'h0);
    xfer(0, 1, 32'h100, 4'hF, 32'hCAFEF00D, rd);
    check_regs(0);
    xfer(1, 1, 7, 4'hF, 32'hCAFEF00D, rd);
    check_regs(1);
    xfer(0, 1, 0, 4'hF, 32'h0BAD0BAD, rd);
    xfer(0, 0, 0, 4'hF, 32'h0, rd);

    // Random traffic
    for (int it = 0; it < 250; it++) begin
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin
        drive_irq(d, $urandom);
      end else begin
        a = (($urandom_range(0, 15)) == 0) ? 32'h100 : 32'($urandom_range(0, nregs(d) + 4));
        if ($urandom_range(0, 1) == 1) begin
          xfer(d, 1, a, 4'($urandom), $urandom, rd);
          check_regs(d);
        end else begin
          xfer(d, 0, a, 4'($urandom), 32'h0, rd);
        end
      end
    end

    // Reset during the wait phase of a write
    xfer(1, 1, 1, 4'hF, 32'h1, rd);
    drive_irq(1, 32'h0);
    drive_irq(1, 32'h1);
    drive_irq(1, 32'h0);
    check("pre_rst_int", 32'(intr[1]), 32'h1);
    @(negedge clk);
    we[1] = 1; adr[1] = 3; sel[1] = 4'hF; dat[1] = 32'hFFFFFFFF; cyc[1] = 1; stb[1] = 1;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    seen = 0;
    repeat (5) begin @(posedge clk); #1; if (ack[1]) seen = 1; end
    check("rst_no_ack", 32'(seen), 32'h0);
    @(negedge clk);
    rst[1] = 1'b0; cyc[1] = 0; stb[1] = 0; we[1] = 0;
    m_reset(1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_ack", 32'(ack[1]), 32'h0);
    check("rst_mid_dat", dout(1), 32'h0);
    check("rst_mid_int", 32'(intr[1]), 32'h0);
    check("req039_reg3", rego1[31:0], 32'h0);
    check_regs(1);
    xfer(1, 0, 1, 4'hF, 32'h0, rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
